// File: rtl/log2_pkg.sv
// Shared types and default sizing for the log2 scheduler slice.
package log2_pkg;

  localparam int unsigned LOG2_N   = 8;
  localparam int unsigned LOG2_R   = 4;
  localparam int unsigned LOG2_M   = $clog2(LOG2_N);
  localparam int unsigned LOG2_IDW = $clog2(LOG2_R);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [LOG2_IDW-1:0] id;
    logic [LOG2_M-1:0]   result;
    logic                exact;
    logic                zero;
  } log2_rsp_t;

endpackage

// File: rtl/log2_engine.sv
// Floor-log2 engine: iterative one-shift-per-cycle by default; a single-cycle
// priority encoder when LOG2_SCHED_FAST_EN is defined. Results are identical.
module log2_engine
  import log2_pkg::*;
#(
  parameter int unsigned N = LOG2_N,
  parameter int unsigned M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] operand_i,
  output logic         done_o,
  output logic [M-1:0] result_o,
  output logic         exact_o,
  output logic         zero_o
);

`ifdef LOG2_SCHED_FAST_EN

  logic [M-1:0] enc_c;
  logic         onehot_c;
  logic [M-1:0] result_q;
  logic         exact_q;
  logic         zero_q;
  logic         done_q;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    enc_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (operand_i[i]) enc_c = M'(i);
    end
    onehot_c = ($countones(operand_i) == 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      exact_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_i) begin
      result_q <= enc_c;
      exact_q  <= onehot_c;
      zero_q   <= (operand_i == '0);
      done_q   <= 1'b1;
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;
  assign exact_o  = exact_q;
  assign zero_o   = zero_q;

`else

  logic [N-1:0] sh_q;
  logic [M-1:0] cnt_q;
  logic         lost_q;
  logic         zero_q;
  logic         done_q;

  // done is precomputed so the FSM sees it in the same cycle sh reaches <= 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      lost_q <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= operand_i;
      cnt_q  <= '0;
      lost_q <= 1'b0;
      zero_q <= (operand_i == '0);
      done_q <= (operand_i <= N'(1));
    end else if (!done_q) begin
      sh_q   <= sh_q >> 1;
      cnt_q  <= cnt_q + M'(1);
      lost_q <= lost_q | sh_q[0];
      done_q <= ((sh_q >> 1) <= N'(1));
    end
  end

  assign done_o   = done_q;
  assign result_o = cnt_q;
  assign exact_o  = !lost_q && !zero_q;
  assign zero_o   = zero_q;

`endif

endmodule

// File: rtl/log2_sched.sv
// Round-robin scheduler sharing one log2_engine among R requesters.
// Engine latency depends on LOG2_SCHED_FAST_EN (see log2_engine).
module log2_sched
  import log2_pkg::*;
#(
  parameter int unsigned N   = LOG2_N,
  parameter int unsigned R   = LOG2_R,
  parameter int unsigned M   = $clog2(N),
  parameter int unsigned IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_value,
  output logic [R-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [M-1:0]   rsp_result,
  output logic           rsp_exact,
  output logic           rsp_zero,
  output logic           busy
);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [M-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_exact_q, rsp_exact_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           busy_q, busy_d;

  logic [IDW-1:0] grant_c;
  logic           any_valid_c;
  logic [R-1:0]   req_ready_c;
  logic           eng_start_c;
  logic [N-1:0]   eng_operand_c;
  logic           eng_done;
  logic [M-1:0]   eng_result;
  logic           eng_exact;
  logic           eng_zero;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                            input int unsigned off);
    return IDW'((32'(base) + off) % R);
  endfunction

  // First valid requester after the last grant, wrapping modulo R.
  always_comb begin
    grant_c     = last_grant_q;
    any_valid_c = 1'b0;
    for (int unsigned k = 1; k <= R; k++) begin
      if (!any_valid_c && req_valid[rr_idx(last_grant_q, k)]) begin
        any_valid_c = 1'b1;
        grant_c     = rr_idx(last_grant_q, k);
      end
    end
  end

  assign eng_operand_c = req_value[32'(grant_c)*N +: N];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_exact_d  = rsp_exact_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready_c  = '0;
    eng_start_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid_c && reset_n) begin
          req_ready_c[grant_c] = 1'b1;
          eng_start_c          = 1'b1;
          id_d                 = grant_c;
          last_grant_d         = grant_c;
          state_d              = CALC;
        end
      end
      CALC: begin
        if (eng_done) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_result_d = eng_result;
          rsp_exact_d  = eng_exact;
          rsp_zero_d   = eng_zero;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(R - 1);
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_exact_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_exact_q  <= rsp_exact_d;
      rsp_zero_q   <= rsp_zero_d;
      busy_q       <= busy_d;
    end
  end

  log2_engine #(
    .N (N),
    .M (M)
  ) u_engine (
    .clk       (clk),
    .rst_n     (reset_n),
    .start_i   (eng_start_c),
    .operand_i (eng_operand_c),
    .done_o    (eng_done),
    .result_o  (eng_result),
    .exact_o   (eng_exact),
    .zero_o    (eng_zero)
  );

  assign req_ready  = req_ready_c;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_exact  = rsp_exact_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;

endmodule
